// File: rtl/mask_gen_pkg.sv
// Shared types and constants for the row-mask generator.
// The LFSR step function is kept here so every consumer shifts with the same taps.
package mask_gen_pkg;

    typedef enum logic [1:0] {
        MT_REPEAT = 2'b00,
        MT_SLIDE  = 2'b01,
        MT_RANDOM = 2'b10,
        MT_RSVD   = 2'b11
    } mask_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } gen_state_e;

    // x^64 + x^63 + x^61 + x^60 + 1, expressed as state bits 63, 62, 60, 59
    localparam logic [63:0] LFSR_TAPS      = 64'hD800_0000_0000_0000;
    localparam logic [63:0] LFSR_ZERO_SEED = 64'h1;

    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return {s[62:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mask_generation_top_lfsr.sv
// Pseudo-random row source: holds the 64-bit LFSR and unrolls MAX_W steps per row.
// row[0] is the earliest output bit (state bit 63 before any shift).
module mask_lfsr_row
    import mask_gen_pkg::*;
#(
    parameter int MAX_W = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             load,
    input  logic             advance,
    input  logic [63:0]      seed,
    output logic [0:MAX_W-1] row
);

    logic [63:0] state;
    logic [63:0] next_state;

    always_comb begin
        next_state = state;
        row        = '0;
        for (int i = 0; i < MAX_W; i++) begin
            row[i]     = next_state[63];
            next_state = lfsr_step(next_state);
        end
    end

    // An all-zero seed would lock the LFSR, so it is replaced on load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LFSR_ZERO_SEED;
        end else if (clk_en) begin
            if (load)
                state <= (seed == '0) ? LFSR_ZERO_SEED : seed;
            else if (advance)
                state <= next_state;
        end
    end

endmodule

// File: rtl/mask_generation_top.sv
// Per-row pixel mask generator: repeated 2-D tile, sliding 1-D pattern or LFSR rows.
// In slide mode mg_mask itself is the rotating row register.
module mask_generation_top
    import mask_gen_pkg::*;
#(
    parameter int MAX_W = 50,
    parameter int MAX_H = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [10:0]      image_sensor_w,
    input  logic [10:0]      image_sensor_h,
    input  logic [4:0]       pattern_w,
    input  logic [4:0]       pattern_h,
    input  logic [0:63]      full_pattern,
    input  logic             start_pattern,
    input  logic             right_sliding,
    input  logic [1:0]       mask_type,
    output logic [0:MAX_W-1] mg_mask,
    output logic             rp_valid
);

    gen_state_e       state;
    mask_type_e       mode;
    logic [10:0]      cfg_w;
    logic [10:0]      cfg_h;
    logic [10:0]      row_cnt;
    logic [4:0]       cfg_pw;
    logic [4:0]       cfg_ph;
    logic [4:0]       tile_row;
    logic [4:0]       tile_col;
    logic [5:0]       tile_base;
    logic [0:63]      cfg_pattern;
    logic [0:MAX_W-1] width_mask;
    logic [0:MAX_W-1] repeat_row;
    logic [0:MAX_W-1] slide_init;
    logic [0:MAX_W-1] slide_next;
    logic [0:MAX_W-1] lfsr_row;
    logic             wrap_last;
    logic             mode_ok;
    logic             lfsr_advance;

    assign mode_ok      = (mask_type == mode);
    assign lfsr_advance = (state != ST_IDLE) && mode_ok && (mode == MT_RANDOM) && !start_pattern;

    // Tile index wraps modulo 64 so oversized PW*PH patterns reuse the low bits.
    always_comb begin
        tile_base  = 6'(11'(tile_row) * 11'(cfg_pw));
        tile_col   = '0;
        width_mask = '0;
        repeat_row = '0;
        slide_init = '0;
        for (int x = 0; x < MAX_W; x++) begin
            width_mask[x] = (11'(x) < cfg_w);
            repeat_row[x] = cfg_pattern[6'(tile_base + 6'(tile_col))] & width_mask[x];
            slide_init[x] = (5'(x) < cfg_pw) && (x < 32) && cfg_pattern[x] && width_mask[x];
            tile_col      = (tile_col + 5'd1 >= cfg_pw) ? 5'd0 : tile_col + 5'd1;
        end
    end

    always_comb begin
        wrap_last = 1'b0;
        for (int x = 0; x < MAX_W; x++)
            if (11'(x) == cfg_w - 11'd1)
                wrap_last = mg_mask[x];
        slide_next = '0;
        for (int x = 0; x < MAX_W; x++) begin
            if (11'(x) < cfg_w) begin
                if (right_sliding)
                    slide_next[x] = (x == 0) ? wrap_last : mg_mask[(x == 0) ? 0 : x - 1];
                else
                    slide_next[x] = (11'(x) == cfg_w - 11'd1) ? mg_mask[0]
                                                               : mg_mask[(x == MAX_W - 1) ? x : x + 1];
            end
        end
    end

    mask_lfsr_row #(.MAX_W(MAX_W)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .load    (start_pattern),
        .advance (lfsr_advance),
        .seed    (full_pattern),
        .row     (lfsr_row)
    );

    // Start latches config; ST_LOAD emits row 0, ST_RUN advances. A mode mismatch parks in idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            mode        <= MT_REPEAT;
            cfg_w       <= '0;
            cfg_h       <= '0;
            cfg_pw      <= 5'd1;
            cfg_ph      <= 5'd1;
            cfg_pattern <= '0;
            row_cnt     <= '0;
            tile_row    <= '0;
            mg_mask     <= '0;
            rp_valid    <= 1'b0;
        end else if (clk_en) begin
            if (start_pattern) begin
                cfg_w       <= (image_sensor_w > 11'(MAX_W)) ? 11'(MAX_W) : image_sensor_w;
                cfg_h       <= (image_sensor_h > 11'(MAX_H)) ? 11'(MAX_H) : image_sensor_h;
                cfg_pw      <= (pattern_w == 5'd0) ? 5'd1 : pattern_w;
                cfg_ph      <= (pattern_h == 5'd0) ? 5'd1 : pattern_h;
                cfg_pattern <= full_pattern;
                mode        <= mask_type_e'(mask_type);
                row_cnt     <= '0;
                tile_row    <= '0;
                mg_mask     <= '0;
                rp_valid    <= 1'b0;
                state       <= (mask_type == MT_RSVD || image_sensor_w == 11'd0) ? ST_IDLE : ST_LOAD;
            end else if (state == ST_IDLE || !mode_ok) begin
                state    <= ST_IDLE;
                mg_mask  <= '0;
                rp_valid <= 1'b0;
            end else begin
                state    <= ST_RUN;
                rp_valid <= 1'b1;
                case (mode)
                    MT_REPEAT: begin
                        mg_mask <= repeat_row;
                        if (row_cnt + 11'd1 >= cfg_h) begin
                            row_cnt  <= '0;
                            tile_row <= '0;
                        end else begin
                            row_cnt  <= row_cnt + 11'd1;
                            tile_row <= (tile_row + 5'd1 >= cfg_ph) ? 5'd0 : tile_row + 5'd1;
                        end
                    end
                    MT_SLIDE:  mg_mask <= (state == ST_LOAD) ? slide_init : slide_next;
                    MT_RANDOM: mg_mask <= lfsr_row & width_mask;
                    default: begin
                        state    <= ST_IDLE;
                        mg_mask  <= '0;
                        rp_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mask_generation_top.sv
// Directed bench for mask_generation_top: slide, repeat, random, mode change, clock enable, reset.
// Expected rows are hand-written pixel lists/tiles plus a bit-serial LFSR reference.
module tb_mask_generation_top;

    localparam int MAX_W = 50;
    localparam int MAX_H = 50;

    logic             clk;
    logic             rst;
    logic             clk_en;
    logic [10:0]      image_sensor_w;
    logic [10:0]      image_sensor_h;
    logic [4:0]       pattern_w;
    logic [4:0]       pattern_h;
    logic [0:63]      full_pattern;
    logic             start_pattern;
    logic             right_sliding;
    logic [1:0]       mask_type;
    logic [0:MAX_W-1] mg_mask;
    logic             rp_valid;

    int               checks;
    int               errors;
    logic [63:0]      ref_lfsr;
    logic [0:MAX_W-1] exp_row;

    mask_generation_top #(.MAX_W(MAX_W), .MAX_H(MAX_H)) dut (
        .clk            (clk),
        .rst            (rst),
        .clk_en         (clk_en),
        .image_sensor_w (image_sensor_w),
        .image_sensor_h (image_sensor_h),
        .pattern_w      (pattern_w),
        .pattern_h      (pattern_h),
        .full_pattern   (full_pattern),
        .start_pattern  (start_pattern),
        .right_sliding  (right_sliding),
        .mask_type      (mask_type),
        .mg_mask        (mg_mask),
        .rp_valid       (rp_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [10:0] w, input logic [10:0] h, input logic [4:0] pw,
                                 input logic [4:0] ph, input logic [63:0] pat, input logic [1:0] mt);
        image_sensor_w = w;
        image_sensor_h = h;
        pattern_w      = pw;
        pattern_h      = ph;
        full_pattern   = pat;
        mask_type      = mt;
        start_pattern  = 1'b1;
        tick();
        start_pattern  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [0:MAX_W-1] exp_mask, input logic exp_valid);
        checks++;
        assert (mg_mask === exp_mask) else begin
            errors++;
            $error("[TB] FAIL %s mask observed %h expected %h", tag, mg_mask, exp_mask);
        end
        checks++;
        assert (rp_valid === exp_valid) else begin
            errors++;
            $error("[TB] FAIL %s valid observed %b expected %b", tag, rp_valid, exp_valid);
        end
    endtask

    function automatic logic [0:MAX_W-1] pixelMask(input int a, input int b, input int c, input int d);
        logic [0:MAX_W-1] m;
        m = '0;
        if (a >= 0) m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        if (c >= 0) m[c] = 1'b1;
        if (d >= 0) m[d] = 1'b1;
        return m;
    endfunction

    function automatic logic [0:MAX_W-1] tileMask(input logic [0:31] p, input int n, input int w);
        logic [0:MAX_W-1] m;
        m = '0;
        for (int x = 0; x < w; x++)
            m[x] = p[x % n];
        return m;
    endfunction

    task automatic refNextRow(output logic [0:MAX_W-1] r);
        for (int i = 0; i < MAX_W; i++) begin
            r[i]     = ref_lfsr[63];
            ref_lfsr = {ref_lfsr[62:0], ref_lfsr[63] ^ ref_lfsr[62] ^ ref_lfsr[60] ^ ref_lfsr[59]};
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        clk_en         = 1'b1;
        image_sensor_w = '0;
        image_sensor_h = '0;
        pattern_w      = '0;
        pattern_h      = '0;
        full_pattern   = '0;
        start_pattern  = 1'b0;
        right_sliding  = 1'b1;
        mask_type      = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("reset_idle", '0, 1'b0);

        // Slide right, W=50, PW=4
        applyStimulus(11'd50, 11'd50, 5'd4, 5'd1, 64'hF000000000000000, 2'b01);
        tick();
        checkOutput("slide_row0", pixelMask(0, 1, 2, 3), 1'b1);
        tick();
        checkOutput("slide_row1", pixelMask(1, 2, 3, 4), 1'b1);
        repeat (46) tick();
        checkOutput("slide_row47", pixelMask(47, 48, 49, 0), 1'b1);
        repeat (3) tick();
        checkOutput("slide_row50", pixelMask(0, 1, 2, 3), 1'b1);

        // Restart, then slide left after row 0
        applyStimulus(11'd50, 11'd50, 5'd4, 5'd1, 64'hF000000000000000, 2'b01);
        tick();
        checkOutput("slide_restart_row0", pixelMask(0, 1, 2, 3), 1'b1);
        right_sliding = 1'b0;
        tick();
        checkOutput("slide_left_row1", pixelMask(49, 0, 1, 2), 1'b1);
        right_sliding = 1'b1;

        // Narrow W=6: rotation wraps at pixel 5
        applyStimulus(11'd6, 11'd50, 5'd4, 5'd1, 64'hF000000000000000, 2'b01);
        repeat (4) tick();
        checkOutput("slide_w6_row3", pixelMask(3, 4, 5, 0), 1'b1);

        // W=1000 clamps to 50, PW=0 acts as 1
        applyStimulus(11'd1000, 11'd50, 5'd0, 5'd1, 64'hF000000000000000, 2'b01);
        tick();
        checkOutput("slide_pw0_row0", pixelMask(0, -1, -1, -1), 1'b1);
        repeat (49) tick();
        checkOutput("slide_clamp_row49", pixelMask(49, -1, -1, -1), 1'b1);
        tick();
        checkOutput("slide_clamp_row50", pixelMask(0, -1, -1, -1), 1'b1);

        // Repeat 4x4 tile over 50x50
        applyStimulus(11'd50, 11'd50, 5'd4, 5'd4, 64'hF0ABC9820EAA17CD, 2'b00);
        tick();
        checkOutput("rep_row0", tileMask(32'hF0000000, 4, 50), 1'b1);
        tick();
        checkOutput("rep_row1", tileMask(32'h00000000, 4, 50), 1'b1);
        tick();
        checkOutput("rep_row2", tileMask(32'hA0000000, 4, 50), 1'b1);
        tick();
        checkOutput("rep_row3", tileMask(32'hB0000000, 4, 50), 1'b1);
        tick();
        checkOutput("rep_row4", tileMask(32'hF0000000, 4, 50), 1'b1);

        // Clock enable low for 5 cycles freezes row 4
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("hold_%0d", i), tileMask(32'hF0000000, 4, 50), 1'b1);
        end
        clk_en = 1'b1;
        tick();
        checkOutput("rep_row5_resume", tileMask(32'h00000000, 4, 50), 1'b1);
        for (int i = 6; i < 50; i++) begin
            tick();
            checks++;
            assert (rp_valid === 1'b1) else begin
                errors++;
                $error("[TB] FAIL rep_valid_row%0d valid observed %b expected 1", i, rp_valid);
            end
        end
        tick();
        checkOutput("rep_row50_wrap", tileMask(32'hF0000000, 4, 50), 1'b1);

        // Mode change drops output until the next start
        mask_type = 2'b01;
        tick();
        checkOutput("mode_change", '0, 1'b0);
        mask_type = 2'b00;
        tick();
        checkOutput("mode_back_no_start", '0, 1'b0);

        // Repeat with W=10, H=3: column masking and row wrap
        applyStimulus(11'd10, 11'd3, 5'd4, 5'd4, 64'hF0ABC9820EAA17CD, 2'b00);
        repeat (3) tick();
        checkOutput("rep_w10_row2", tileMask(32'hA0000000, 4, 10), 1'b1);
        tick();
        checkOutput("rep_h3_wrap", tileMask(32'hF0000000, 4, 10), 1'b1);

        // PW=20, PH=4: row 3 indices 60..63 then wrap to 0..15
        applyStimulus(11'd50, 11'd50, 5'd20, 5'd4, 64'hF0ABC9820EAA17CD, 2'b00);
        tick();
        checkOutput("rep_pw20_row0", tileMask(32'hF0ABC000, 20, 50), 1'b1);
        repeat (3) tick();
        checkOutput("rep_pw20_row3_wrap64", tileMask(32'hDF0AB000, 20, 50), 1'b1);

        // Reserved mode and zero width stay silent
        applyStimulus(11'd50, 11'd50, 5'd4, 5'd4, 64'hF0ABC9820EAA17CD, 2'b11);
        tick();
        checkOutput("mode_rsvd", '0, 1'b0);
        applyStimulus(11'd0, 11'd50, 5'd4, 5'd4, 64'hF0ABC9820EAA17CD, 2'b00);
        tick();
        checkOutput("width_zero", '0, 1'b0);

        // Random: 1000 rows against the serial reference
        applyStimulus(11'd50, 11'd50, 5'd4, 5'd4, 64'hAAAAAAAA00000000, 2'b10);
        ref_lfsr = 64'hAAAAAAAA00000000;
        tick();
        checkOutput("rand_row0_hand", 50'h2_AAAA_AAA8_0000, 1'b1);
        refNextRow(exp_row);
        checkOutput("rand_row0", exp_row, 1'b1);
        for (int i = 1; i < 1000; i++) begin
            tick();
            refNextRow(exp_row);
            checkOutput($sformatf("rand_row%0d", i), exp_row, 1'b1);
        end

        applyStimulus(11'd50, 11'd50, 5'd4, 5'd4, 64'hAAAAAAAA00000000, 2'b10);
        ref_lfsr = 64'hAAAAAAAA00000000;
        for (int i = 0; i < 3; i++) begin
            tick();
            refNextRow(exp_row);
            checkOutput($sformatf("rand_restart_row%0d", i), exp_row, 1'b1);
        end

        applyStimulus(11'd50, 11'd50, 5'd4, 5'd4, 64'h0, 2'b10);
        ref_lfsr = 64'h1;
        for (int i = 0; i < 4; i++) begin
            tick();
            refNextRow(exp_row);
            checkOutput($sformatf("rand_seed0_row%0d", i), exp_row, 1'b1);
        end

        // Asynchronous reset mid-run
        rst = 1'b1;
        #1;
        checkOutput("reset_async", '0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("reset_hold_%0d", i), '0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
